// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: load port, hazard/branch controls from downstream, IF/ID outputs to decode.
interface instr_fetch_stage_if #(
  parameter int unsigned ADDR_W = 6
);
  // Inputs to the fetch stage
  logic              LoadInstructions;
  logic [31:0]       Instruction;
  logic              Stall;
  logic              BranchTaken;
  logic [31:0]       BranchTarget;

  // Outputs from the fetch stage
  logic [31:0]       PC;
  logic [31:0]       IF_ID_Instr;
  logic [31:0]       IF_ID_PCPlus4;
  logic              IF_ID_Valid;
  logic [ADDR_W:0]   LoadCount;
  logic              Full;

  // Driver side (loader / hazard unit / decode consumer)
  modport master (
    output LoadInstructions, Instruction, Stall, BranchTaken, BranchTarget,
    input  PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, LoadCount, Full
  );

  // Fetch stage side
  modport slave (
    input  LoadInstructions, Instruction, Stall, BranchTaken, BranchTarget,
    output PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, LoadCount, Full
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: serially loaded instruction memory, PC register and IF/ID register.
// Memory contents and LoadCount are deliberately outside the reset domain so a loaded program
// survives a reset pulse.
module instr_fetch_stage #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic               clk,
  input  logic               Reset,
  instr_fetch_stage_if.slave bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned IDX_W = XLEN - 2;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              full_q, full_d;
  logic [CNT_W-1:0]  wptr_q, wptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [XLEN-1:0]   mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;

  logic [IDX_W-1:0]  pc_idx;
  logic [IDX_W-1:0]  tgt_idx;
  logic [XLEN-1:0]   tgt_aligned;
  logic [XLEN-1:0]   rd_word;
  logic              pc_fetchable;
  logic              tgt_fetchable;
  logic              unused_tgt_lsbs;

  // Word indices; anything at or beyond DEPTH counts as past the program (no aliasing).
  assign pc_idx        = pc_q[XLEN-1:2];
  assign tgt_idx       = bus.BranchTarget[XLEN-1:2];
  assign tgt_aligned   = {bus.BranchTarget[XLEN-1:2], 2'b00};
  assign pc_fetchable  = (pc_idx < IDX_W'(cnt_q)) && (pc_idx < IDX_W'(DEPTH));
  assign tgt_fetchable = (tgt_idx < IDX_W'(cnt_q)) && (tgt_idx < IDX_W'(DEPTH));
  assign unused_tgt_lsbs = ^bus.BranchTarget[1:0];

  // Asynchronous instruction read; byte offset bits are ignored.
  assign rd_word = mem_q[pc_q[ADDR_W+1:2]];

  // State register plus PC, IF/ID, write pointer and Full flag.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      full_q  <= full_d;
      wptr_q  <= wptr_d;
    end
  end

  // Program storage and load count, intentionally not reset.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    if (mem_we) begin
      mem_q[mem_waddr] <= bus.Instruction;
    end
  end

  // Mode for this edge: load wins, otherwise run while the PC points inside the program.
  always_comb begin
    state_d = state_q;
    if (bus.LoadInstructions) begin
      state_d = ST_LOAD;
    end else if (pc_fetchable) begin
      state_d = ST_RUN;
    end else begin
      state_d = ST_HALT;
    end
  end

  // Datapath updates for the selected mode.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc4_d     = pc4_q;
    valid_d   = valid_q;
    full_d    = full_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = '0;

    unique case (state_d)
      ST_LOAD: begin
        pc_d    = '0;
        instr_d = '0;
        valid_d = 1'b0;
        if (state_q != ST_LOAD) begin
          // New session restarts at word 0 and clears the overflow flag.
          mem_we    = 1'b1;
          mem_waddr = '0;
          wptr_d    = CNT_W'(1);
          cnt_d     = CNT_W'(1);
          full_d    = 1'b0;
        end else if (wptr_q < CNT_W'(DEPTH)) begin
          mem_we    = 1'b1;
          mem_waddr = wptr_q[ADDR_W-1:0];
          wptr_d    = wptr_q + CNT_W'(1);
          cnt_d     = wptr_q + CNT_W'(1);
        end else begin
          full_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (bus.BranchTaken) begin
          pc_d    = tgt_aligned;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (!bus.Stall) begin
          instr_d = rd_word;
          pc4_d   = pc_q + XLEN'(4);
          valid_d = 1'b1;
          pc_d    = pc_q + XLEN'(4);
        end
      end

      default: begin
        // Halted: only a redirect into the loaded program restarts fetch.
        if (bus.BranchTaken && tgt_fetchable) begin
          pc_d    = tgt_aligned;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (!bus.Stall) begin
          instr_d = '0;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  assign bus.PC            = pc_q;
  assign bus.IF_ID_Instr   = instr_q;
  assign bus.IF_ID_PCPlus4 = pc4_q;
  assign bus.IF_ID_Valid   = valid_q;
  assign bus.LoadCount     = cnt_q;
  assign bus.Full          = full_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed vector table, hand-written load/reset sequences,
// then randomized traffic checked against a word-level reference model.
module tb_instr_fetch_stage;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic Reset;

  always #5 clk = ~clk;

  instr_fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  int unsigned m_cnt = 0;
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid, m_full, m_loading;

  typedef struct {
    bit          stall;
    bit          br;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    bit          valid;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] prog [7];

  function automatic vec_t mk(bit s, bit b, logic [31:0] t, logic [31:0] p,
                              logic [31:0] ins, logic [31:0] p4, bit v);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.pc = p; r.instr = ins; r.pc4 = p4; r.valid = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_full = 0; m_loading = 0;
  endtask

  // One clock edge of the fetch stage, described by word index and program length.
  task automatic model_edge();
    int unsigned idx  = m_pc >> 2;
    int unsigned tidx = bus.BranchTarget >> 2;
    bit can_fetch = (idx < m_cnt) && (idx < DEPTH);
    bit tgt_ok    = (tidx < m_cnt) && (tidx < DEPTH);
    if (bus.LoadInstructions) begin
      if (!m_loading) begin
        m_cnt = 0; m_full = 0;
      end
      if (m_cnt < DEPTH) begin
        m_mem[m_cnt] = bus.Instruction;
        m_cnt++;
      end else begin
        m_full = 1;
      end
      m_pc = 0; m_instr = 0; m_valid = 0;
    end else if (bus.BranchTaken && (can_fetch || tgt_ok)) begin
      m_pc = bus.BranchTarget & 32'hFFFF_FFFC;
      m_instr = 0; m_valid = 0;
    end else if (bus.Stall) begin
      m_pc = m_pc;
    end else if (can_fetch) begin
      m_instr = m_mem[idx];
      m_pc4   = m_pc + 32'd4;
      m_valid = 1;
      m_pc    = m_pc + 32'd4;
    end else begin
      m_instr = 0; m_valid = 0;
    end
    m_loading = bus.LoadInstructions;
  endtask

  task automatic tick();
    if (Reset) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input int c);
    chk($sformatf("rnd%0d.PC", c),        bus.PC,            m_pc);
    chk($sformatf("rnd%0d.Instr", c),     bus.IF_ID_Instr,   m_instr);
    chk($sformatf("rnd%0d.PCPlus4", c),   bus.IF_ID_PCPlus4, m_pc4);
    chk($sformatf("rnd%0d.Valid", c),     32'(bus.IF_ID_Valid), 32'(m_valid));
    chk($sformatf("rnd%0d.LoadCount", c), 32'(bus.LoadCount),   m_cnt);
    chk($sformatf("rnd%0d.Full", c),      32'(bus.Full),        32'(m_full));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, %0d tests so far", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    int burst = 0;

    for (int i = 0; i < 7; i++)
      prog[i] = {6'h23, 5'd0, 5'(10 - i / 2), 16'(100 - 5 * i)};

    tbl[0]  = mk(0, 0, 32'd0,  32'd4,  prog[0], 32'd4,  1);
    tbl[1]  = mk(0, 0, 32'd0,  32'd8,  prog[1], 32'd8,  1);
    tbl[2]  = mk(1, 0, 32'd0,  32'd8,  prog[1], 32'd8,  1);
    tbl[3]  = mk(1, 0, 32'd0,  32'd8,  prog[1], 32'd8,  1);
    tbl[4]  = mk(0, 0, 32'd0,  32'd12, prog[2], 32'd12, 1);
    tbl[5]  = mk(0, 0, 32'd0,  32'd16, prog[3], 32'd16, 1);
    tbl[6]  = mk(1, 1, 32'hE,  32'd12, 32'd0,   32'd16, 0);
    tbl[7]  = mk(0, 0, 32'd0,  32'd16, prog[3], 32'd16, 1);
    tbl[8]  = mk(0, 0, 32'd0,  32'd20, prog[4], 32'd20, 1);
    tbl[9]  = mk(0, 0, 32'd0,  32'd24, prog[5], 32'd24, 1);
    tbl[10] = mk(0, 0, 32'd0,  32'd28, prog[6], 32'd28, 1);
    tbl[11] = mk(0, 0, 32'd0,  32'd28, 32'd0,   32'd28, 0);
    tbl[12] = mk(0, 0, 32'd0,  32'd28, 32'd0,   32'd28, 0);
    tbl[13] = mk(1, 0, 32'd0,  32'd28, 32'd0,   32'd28, 0);
    tbl[14] = mk(0, 1, 32'd4,  32'd4,  32'd0,   32'd28, 0);
    tbl[15] = mk(0, 0, 32'd0,  32'd8,  prog[1], 32'd8,  1);

    bus.LoadInstructions = 0;
    bus.Instruction      = 0;
    bus.Stall            = 0;
    bus.BranchTaken      = 0;
    bus.BranchTarget     = 0;
    Reset = 1;
    #1 Reset = 0;
    model_reset();
    #1;
    chk("rst.PC",      bus.PC,            32'd0);
    chk("rst.Instr",   bus.IF_ID_Instr,   32'd0);
    chk("rst.PCPlus4", bus.IF_ID_PCPlus4, 32'd0);
    chk("rst.Valid",   32'(bus.IF_ID_Valid), 32'd0);
    chk("rst.Full",    32'(bus.Full),        32'd0);

    // Load the 7-word program, then pulse reset: the program must survive.
    @(posedge clk); #1;
    Reset = 1;
    bus.LoadInstructions = 1;
    for (int i = 0; i < 7; i++) begin
      bus.Instruction = prog[i];
      tick();
    end
    chk("load7.LoadCount", 32'(bus.LoadCount), 32'd7);
    chk("load7.PC",        bus.PC,             32'd0);
    bus.LoadInstructions = 0;
    Reset = 0;
    model_reset();
    tick();
    Reset = 1;
    chk("rstkeep.LoadCount", 32'(bus.LoadCount), 32'd7);

    // Directed run: sequential fetch, stall, branch+stall, halt, branch out of halt.
    for (int i = 0; i < 16; i++) begin
      bus.Stall        = tbl[i].stall;
      bus.BranchTaken  = tbl[i].br;
      bus.BranchTarget = tbl[i].tgt;
      tick();
      chk($sformatf("vec%0d.PC", i),      bus.PC,            tbl[i].pc);
      chk($sformatf("vec%0d.Instr", i),   bus.IF_ID_Instr,   tbl[i].instr);
      chk($sformatf("vec%0d.PCPlus4", i), bus.IF_ID_PCPlus4, tbl[i].pc4);
      chk($sformatf("vec%0d.Valid", i),   32'(bus.IF_ID_Valid), 32'(tbl[i].valid));
    end
    bus.Stall = 0; bus.BranchTaken = 0; bus.BranchTarget = 0;

    // Overflow: DEPTH+3 words, extra words dropped, Full sticky.
    bus.LoadInstructions = 1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      bus.Instruction = 32'hA500_0000 | 32'(i);
      tick();
      if (i == 0) begin
        chk("ovf.first.PC",        bus.PC,               32'd0);
        chk("ovf.first.Valid",     32'(bus.IF_ID_Valid), 32'd0);
        chk("ovf.first.LoadCount", 32'(bus.LoadCount),   32'd1);
      end
      if (i == DEPTH - 1) begin
        chk("ovf.at64.LoadCount", 32'(bus.LoadCount), 32'd64);
        chk("ovf.at64.Full",      32'(bus.Full),      32'd0);
      end
      if (i == DEPTH) chk("ovf.at65.Full", 32'(bus.Full), 32'd1);
    end
    chk("ovf.end.LoadCount", 32'(bus.LoadCount), 32'd64);
    chk("ovf.end.Full",      32'(bus.Full),      32'd1);
    bus.LoadInstructions = 0;
    bus.BranchTaken  = 1;
    bus.BranchTarget = 32'd252;
    tick();
    chk("ovf.br.PC",    bus.PC,               32'd252);
    chk("ovf.br.Valid", 32'(bus.IF_ID_Valid), 32'd0);
    bus.BranchTaken = 0;
    tick();
    chk("ovf.last.Instr",   bus.IF_ID_Instr,      32'hA500_003F);
    chk("ovf.last.PCPlus4", bus.IF_ID_PCPlus4,    32'd256);
    chk("ovf.last.Valid",   32'(bus.IF_ID_Valid), 32'd1);
    tick();
    chk("ovf.halt.PC",    bus.PC,               32'd256);
    chk("ovf.halt.Valid", 32'(bus.IF_ID_Valid), 32'd0);
    chk("ovf.halt.Full",  32'(bus.Full),        32'd1);

    // Reset mid-cycle during a 3-word load.
    bus.LoadInstructions = 1;
    for (int i = 0; i < 3; i++) begin
      bus.Instruction = 32'h1111_0000 | 32'(i);
      tick();
    end
    chk("mid.LoadCount", 32'(bus.LoadCount), 32'd3);
    chk("mid.Full",      32'(bus.Full),      32'd0);
    @(negedge clk);
    Reset = 0;
    bus.LoadInstructions = 0;
    model_reset();
    #1;
    chk("async.PC",        bus.PC,               32'd0);
    chk("async.PCPlus4",   bus.IF_ID_PCPlus4,    32'd0);
    chk("async.Instr",     bus.IF_ID_Instr,      32'd0);
    chk("async.Valid",     32'(bus.IF_ID_Valid), 32'd0);
    chk("async.LoadCount", 32'(bus.LoadCount),   32'd3);
    tick();
    Reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid.run%0d.Instr", i),   bus.IF_ID_Instr,      32'h1111_0000 | 32'(i));
      chk($sformatf("mid.run%0d.PCPlus4", i), bus.IF_ID_PCPlus4,    32'(4 * (i + 1)));
      chk($sformatf("mid.run%0d.Valid", i),   32'(bus.IF_ID_Valid), 32'd1);
    end
    tick();
    chk("mid.halt.Valid", 32'(bus.IF_ID_Valid), 32'd0);
    chk("mid.halt.PC",    bus.PC,               32'd12);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      if (burst == 0 && $urandom_range(0, 99) == 0) begin
        bus.LoadInstructions = 0;
        Reset = 0;
        model_reset();
        tick();
        Reset = 1;
      end
      if (burst > 0) begin
        bus.LoadInstructions = 1;
        burst--;
      end else if ($urandom_range(0, 99) < 3) begin
        bus.LoadInstructions = 1;
        burst = ($urandom_range(0, 9) == 0) ? 69 : int'($urandom_range(0, 11));
      end else begin
        bus.LoadInstructions = 0;
      end
      bus.Instruction  = $urandom;
      bus.Stall        = ($urandom_range(0, 3) == 0);
      bus.BranchTaken  = ($urandom_range(0, 7) == 0);
      bus.BranchTarget = ($urandom_range(0, 15) == 0) ? ($urandom | 32'hF000_0000)
                                                      : 32'($urandom_range(0, (m_cnt + 2) * 4 + 3));
      tick();
      chk_model(c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
